// File: rtl/alu_sm_accum.sv
// Saturating signed accumulator fed by sign/magnitude samples, with a
// start / accumulate / result-handshake control FSM.
module alu_sm_accum #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ACC_WIDTH = 8,
  parameter int unsigned LEN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_mag,
  input  logic                 in_sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_sat,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   r_sat;
  logic [LEN_WIDTH-1:0]   r_cnt;
  logic [LEN_WIDTH-1:0]   r_len;

  logic                   w_start;
  logic                   w_xfer;
  logic                   w_last;
  logic [LEN_WIDTH-1:0]   w_cnt_inc;
  logic [ACC_WIDTH:0]     w_mag_ext;
  logic [ACC_WIDTH:0]     w_val;
  logic [ACC_WIDTH:0]     w_sum;
  logic                   w_ovf;
  logic [ACC_WIDTH-1:0]   w_acc_next;

  assign w_start   = (r_state == IDLE) && start;
  assign w_xfer    = (r_state == ACCUM) && in_valid;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = w_xfer && (w_cnt_inc == r_len);

  // One guard bit above the accumulator: the sum of an ACC_WIDTH value and a
  // sample narrower than ACC_WIDTH never overflows ACC_WIDTH+1 bits, so the
  // top two bits disagreeing is an exact overflow test.
  assign w_mag_ext = {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_mag};
  assign w_val     = in_sgn ? (~w_mag_ext + 1'b1) : w_mag_ext;
  assign w_sum     = {r_acc[ACC_WIDTH-1], r_acc} + w_val;
  assign w_ovf     = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

  always_comb begin
    w_acc_next = w_sum[ACC_WIDTH-1:0];
    if (w_ovf) begin
      w_acc_next = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
        busy         = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_sat <= 1'b0;
      r_cnt <= '0;
      r_len <= '0;
    end else if (w_start) begin
      r_acc <= '0;
      r_sat <= 1'b0;
      r_cnt <= '0;
      r_len <= len;
    end else if (w_xfer) begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_inc;
      if (w_ovf) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign out_acc = r_acc;
  assign out_sat = r_sat;

endmodule

// File: tb/tb_alu_sm_accum.sv
// Directed self-checking bench for alu_sm_accum (WIDTH=4, ACC_WIDTH=8):
// a vector table of whole accumulations plus hand-written handshake/reset cases.
module tb_alu_sm_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_mag;
  logic       in_sgn;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_acc;
  logic       out_sat;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sm_accum #(.WIDTH(4), .ACC_WIDTH(8), .LEN_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_mag(in_mag), .in_sgn(in_sgn),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  // Each sample is {sgn, mag}.
  typedef struct packed {
    logic [3:0]       len;
    logic [15:0][4:0] samp;
    logic [7:0]       exp_acc;
    logic             exp_sat;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    start = 1'b1;
    len   = v.len;
    tick();
    start = 1'b0;
    if (v.len == 4'd0) begin
      check($sformatf("v%0d len0 out_valid", idx), {31'd0, out_valid}, 32'd1);
    end else begin
      check($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
      for (int k = 0; k < int'(v.len); k++) begin
        in_valid = 1'b1;
        in_sgn   = v.samp[k][4];
        in_mag   = v.samp[k][3:0];
        if (k == int'(v.len) - 1)
          check($sformatf("v%0d out_valid early", idx), {31'd0, out_valid}, 32'd0);
        tick();
      end
      in_valid = 1'b0;
      check($sformatf("v%0d out_valid", idx), {31'd0, out_valid}, 32'd1);
    end
    check($sformatf("v%0d out_acc", idx), {24'd0, out_acc}, {24'd0, v.exp_acc});
    check($sformatf("v%0d out_sat", idx), {31'd0, out_sat}, {31'd0, v.exp_sat});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("v%0d idle out_valid", idx), {31'd0, out_valid}, 32'd0);
    check($sformatf("v%0d idle busy", idx), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d idle out_acc held", idx), {24'd0, out_acc}, {24'd0, v.exp_acc});
  endtask

  initial begin
    for (int i = 0; i < NVEC; i++) vecs[i] = '0;
    // 5 - 7 + 2 = 0
    vecs[0].len = 4'd3;
    vecs[0].samp[0] = {1'b0, 4'd5}; vecs[0].samp[1] = {1'b1, 4'd7}; vecs[0].samp[2] = {1'b0, 4'd2};
    vecs[0].exp_acc = 8'h00; vecs[0].exp_sat = 1'b0;
    // 15 * 15 saturates high
    vecs[1].len = 4'd15;
    for (int k = 0; k < 15; k++) vecs[1].samp[k] = {1'b0, 4'd15};
    vecs[1].exp_acc = 8'h7F; vecs[1].exp_sat = 1'b1;
    // 15 * -15 saturates low
    vecs[2].len = 4'd15;
    for (int k = 0; k < 15; k++) vecs[2].samp[k] = {1'b1, 4'd15};
    vecs[2].exp_acc = 8'h80; vecs[2].exp_sat = 1'b1;
    // clamp to 127 then -15 -> 112, no wrap
    vecs[3].len = 4'd10;
    for (int k = 0; k < 9; k++) vecs[3].samp[k] = {1'b0, 4'd15};
    vecs[3].samp[9] = {1'b1, 4'd15};
    vecs[3].exp_acc = 8'h70; vecs[3].exp_sat = 1'b1;
    // len 0
    vecs[4].len = 4'd0; vecs[4].exp_acc = 8'h00; vecs[4].exp_sat = 1'b0;
    // negative zero
    vecs[5].len = 4'd1; vecs[5].samp[0] = {1'b1, 4'd0};
    vecs[5].exp_acc = 8'h00; vecs[5].exp_sat = 1'b0;
    // 7 - 3 = 4
    vecs[6].len = 4'd2; vecs[6].samp[0] = {1'b0, 4'd7}; vecs[6].samp[1] = {1'b1, 4'd3};
    vecs[6].exp_acc = 8'h04; vecs[6].exp_sat = 1'b0;
    // -8 -8 -8 +1 = -23
    vecs[7].len = 4'd4;
    for (int k = 0; k < 3; k++) vecs[7].samp[k] = {1'b1, 4'd8};
    vecs[7].samp[3] = {1'b0, 4'd1};
    vecs[7].exp_acc = 8'hE9; vecs[7].exp_sat = 1'b0;
    // single max sample
    vecs[8].len = 4'd1; vecs[8].samp[0] = {1'b0, 4'd15};
    vecs[8].exp_acc = 8'h0F; vecs[8].exp_sat = 1'b0;
    // exactly +127: no saturation
    vecs[9].len = 4'd9;
    for (int k = 0; k < 8; k++) vecs[9].samp[k] = {1'b0, 4'd15};
    vecs[9].samp[8] = {1'b0, 4'd7};
    vecs[9].exp_acc = 8'h7F; vecs[9].exp_sat = 1'b0;
    // exactly -128: no saturation
    vecs[10].len = 4'd9;
    for (int k = 0; k < 8; k++) vecs[10].samp[k] = {1'b1, 4'd15};
    vecs[10].samp[8] = {1'b1, 4'd8};
    vecs[10].exp_acc = 8'h80; vecs[10].exp_sat = 1'b0;

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_mag = '0; in_sgn = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset out_acc", {24'd0, out_acc}, 32'd0);
    check("reset out_sat", {31'd0, out_sat}, 32'd0);

    // in_valid and out_ready in IDLE are ignored
    in_valid = 1'b1; in_mag = 4'd9; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("idle ignores in_valid", {24'd0, out_acc}, 32'd0);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // DONE held for 5 cycles; start and in_valid must be ignored
    start = 1'b1; len = 4'd1; tick(); start = 1'b0;
    in_valid = 1'b1; in_sgn = 1'b0; in_mag = 4'd3; tick();
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; len = 4'd5; in_valid = 1'b1; in_mag = 4'd4;
      check($sformatf("hold c%0d out_valid", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("hold c%0d out_acc", c), {24'd0, out_acc}, 32'd3);
      check($sformatf("hold c%0d in_ready", c), {31'd0, in_ready}, 32'd0);
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    check("hold end out_acc", {24'd0, out_acc}, 32'd3);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("hold release out_valid", {31'd0, out_valid}, 32'd0);

    // bubble between samples leaves the accumulator alone
    start = 1'b1; len = 4'd2; tick(); start = 1'b0;
    in_valid = 1'b1; in_sgn = 1'b0; in_mag = 4'd6; tick();
    in_valid = 1'b0; tick();
    check("bubble acc", {24'd0, out_acc}, 32'd6);
    check("bubble still accum", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_sgn = 1'b1; in_mag = 4'd1; tick();
    in_valid = 1'b0;
    check("bubble out_valid", {31'd0, out_valid}, 32'd1);
    check("bubble result", {24'd0, out_acc}, 32'd5);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // reset mid-accumulation, with competing controls in the same cycle
    start = 1'b1; len = 4'd4; tick(); start = 1'b0;
    in_valid = 1'b1; in_sgn = 1'b0; in_mag = 4'd6; tick(); tick();
    check("pre-rst acc", {24'd0, out_acc}, 32'd12);
    rst = 1'b1; start = 1'b1; out_ready = 1'b1; tick();
    rst = 1'b0; start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst out_acc", {24'd0, out_acc}, 32'd0);
    check("rst out_sat", {31'd0, out_sat}, 32'd0);

    // fresh start after reset: 1 + 2 = 3
    start = 1'b1; len = 4'd2; tick(); start = 1'b0;
    in_valid = 1'b1; in_mag = 4'd1; tick();
    in_mag = 4'd2; tick();
    in_valid = 1'b0;
    check("post-rst out_valid", {31'd0, out_valid}, 32'd1);
    check("post-rst out_acc", {24'd0, out_acc}, 32'd3);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sm_accum.md
ALU_SM_ACCUM -- requirements
Module: alu_sm_accum

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4: magnitude width of each input sample, matching the subtractor WIDTH.
REQ-002 The module SHALL have parameter ACC_WIDTH, default 8: two's-complement accumulator width; ACC_WIDTH > WIDTH.
REQ-003 The module SHALL have parameter LEN_WIDTH, default 4: width of the sample-count input.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-006 Port: rst  input  1  synchronous, active-high reset.
REQ-007 Port: start  input  1  single-cycle request to begin a new accumulation.
REQ-008 Port: len  input  LEN_WIDTH  number of samples to accumulate; sampled on an accepted start.
REQ-009 Port: in_valid  input  1  in_mag/in_sgn carry a sample.
REQ-010 Port: in_ready  output  1  block accepts a sample this cycle.
REQ-011 Port: in_mag  input  WIDTH  sample magnitude (subtractor sub output).
REQ-012 Port: in_sgn  input  1  sample sign (subtractor sgn output); 1 = negative.
REQ-013 Port: out_valid  output  1  result available.
REQ-014 Port: out_ready  input  1  consumer accepts the result.
REQ-015 Port: out_acc  output  ACC_WIDTH  signed two's-complement result.
REQ-016 Port: out_sat  output  1  sticky flag: saturation occurred during this accumulation.
REQ-017 Port: busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-019 In IDLE, start=1 SHALL clear the accumulator, out_sat and the sample counter, and SHALL latch len.
REQ-019a In IDLE, start=1 SHALL then go to DONE if len=0, otherwise to ACCUM.
REQ-020 start SHALL be ignored in ACCUM and DONE.
REQ-021 in_ready SHALL be 1 exactly when the state is ACCUM, decoded from registered state only.
REQ-022 A sample SHALL transfer on a cycle with in_valid=1 and in_ready=1; no other cycle changes the accumulator.
REQ-023 Sample value SHALL be +in_mag when in_sgn=0 and -in_mag when in_sgn=1; sgn=1 with mag=0 SHALL equal 0.
REQ-024 Each transfer SHALL set acc to acc + value, clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
REQ-024a On any clamp in REQ-024, out_sat SHALL be set to 1, and it SHALL stay 1 until the next accepted start or rst.
REQ-025 After a clamp, later samples SHALL add to the clamped value; no wrap-around is permitted.
REQ-026 The transfer of the len-th sample SHALL move ACCUM to DONE; out_valid SHALL rise on the cycle after that transfer.
REQ-027 In DONE, out_valid SHALL be 1, and out_acc and out_sat SHALL stay stable until out_ready=1.
REQ-027a out_ready=1 in DONE SHALL return the FSM to IDLE, with out_valid=0 on the next cycle.
REQ-028 out_acc and out_sat SHALL keep their last values in IDLE until the next accepted start.
REQ-029 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside ACCUM.
REQ-030 Samples SHALL be accepted back-to-back, one per cycle, with no bubble.

Reset
REQ-031 On rst=1 the module SHALL enter IDLE at the clock edge, from any state, discarding any accumulation in progress.
REQ-032 After reset: in_ready=0, out_valid=0, busy=0, out_acc=0, out_sat=0, sample counter=0.
REQ-033 rst SHALL take priority over start, in_valid and out_ready in the same cycle.

Verification (WIDTH=4, ACC_WIDTH=8)
REQ-034 Scenario: start, len=3; samples (0,5), (1,7), (0,2) back-to-back -> out_acc=0, out_sat=0, out_valid one cycle after the 3rd transfer.
REQ-035 Scenario: len=15; fifteen samples of (0,15) -> out_acc=127, out_sat=1.
REQ-035a Scenario: len=15; fifteen samples of (1,15) -> out_acc=-128, out_sat=1.
REQ-036 Scenario: len=10; nine samples of (0,15), then (1,15) -> out_acc=112, out_sat=1.
REQ-037 Scenario: len=0 -> out_valid=1 on the cycle after start, out_acc=0.
REQ-037a Scenario: sample (1,0) with len=1 -> out_acc=0, out_sat=0.
REQ-038 Scenario: out_ready held 0 for 5 cycles in DONE -> out_valid and out_acc stable; start pulses during those cycles are ignored.
REQ-039 Scenario: rst asserted after 2 of 4 samples -> all outputs at reset values next cycle.
REQ-039a Scenario: a fresh start after REQ-039 accumulates from 0.
